// File: rtl/wb_prog_loader_if.sv
// Bus bundle between the program loader and its neighbours: the Wishbone
// master port towards the mcu slave and the instruction stream feeding it.
interface wb_prog_loader_if #(
    parameter int LOG_CORES   = 1,
    parameter int PC_WIDTH    = 3,
    parameter int INSTR_WIDTH = 32,
    parameter int WB_WIDTH    = 32
);
    logic                   wbm_cyc_o;
    logic                   wbm_stb_o;
    logic                   wbm_we_o;
    logic [WB_WIDTH-1:0]    wbm_adr_o;
    logic [WB_WIDTH-1:0]    wbm_dat_o;
    logic                   wbm_ack_i;

    logic                   in_valid;
    logic                   in_ready;
    logic [LOG_CORES-1:0]   in_core;
    logic [PC_WIDTH-1:0]    in_pc;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic                   in_last;

    // Loader side: drives the Wishbone request, consumes the stream.
    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i,
        input  in_valid, in_core, in_pc, in_instr, in_last,
        output in_ready
    );

    // Environment side: Wishbone slave plus instruction source.
    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i,
        output in_valid, in_core, in_pc, in_instr, in_last,
        input  in_ready
    );
endinterface

// File: rtl/wb_prog_loader.sv
// Wishbone master that programs the mcu: program-mode on, instruction words,
// pin directions, program-mode off. Every transfer is guarded by an ack timeout.
module wb_prog_loader #(
    parameter int LOG_CORES   = 1,
    parameter int PC_WIDTH    = 3,
    parameter int INSTR_WIDTH = 32,
    parameter int IO_PINS     = 8,
    parameter int WB_WIDTH    = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start,
    input  logic [IO_PINS-1:0] pin_dir,
    wb_prog_loader_if.master   bus,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]   WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WB_WIDTH-1:0] WB_ZERO   = {WB_WIDTH{1'b0}};
    localparam logic [WB_WIDTH-1:0] DAT_ONE   = {{(WB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WB_WIDTH-1:0] ADR_PROG  = {2'b01, {(WB_WIDTH-2){1'b0}}};
    localparam logic [WB_WIDTH-1:0] ADR_PINS  = ADR_PROG | DAT_ONE;

    typedef enum logic [2:0] {
        S_IDLE, S_PROG_ON, S_INSTR_WAIT, S_INSTR_WR, S_PINS, S_PROG_OFF
    } state_t;

    // Instruction memory address: core index above the per-core pc.
    function automatic logic [WB_WIDTH-1:0] instr_adr(input logic [LOG_CORES-1:0] core,
                                                      input logic [PC_WIDTH-1:0]  pc);
        logic [WB_WIDTH-1:0] a;
        a = WB_ZERO;
        a[LOG_CORES+PC_WIDTH-1:0] = {core, pc};
        return a;
    endfunction

    function automatic logic [WB_WIDTH-1:0] zext_instr(input logic [INSTR_WIDTH-1:0] w);
        logic [WB_WIDTH-1:0] d;
        d = WB_ZERO;
        d[INSTR_WIDTH-1:0] = w;
        return d;
    endfunction

    function automatic logic [WB_WIDTH-1:0] zext_pins(input logic [IO_PINS-1:0] p);
        logic [WB_WIDTH-1:0] d;
        d = WB_ZERO;
        d[IO_PINS-1:0] = p;
        return d;
    endfunction

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic [WB_WIDTH-1:0] adr_q, adr_d;
    logic [WB_WIDTH-1:0] dat_q, dat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                last_q, last_d;
    logic [IO_PINS-1:0]  pin_q, pin_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        wait_d  = wait_q;
        last_d  = last_q;
        pin_d   = pin_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PROG_ON;
                    pin_d   = pin_dir;
                    err_d   = 1'b0;
                    cyc_d   = 1'b1;
                    adr_d   = ADR_PROG;
                    dat_d   = DAT_ONE;
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    cyc_d = 1'b0;
                end
            end
            S_INSTR_WAIT: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d = S_INSTR_WR;
                    adr_d   = instr_adr(bus.in_core, bus.in_pc);
                    dat_d   = zext_instr(bus.in_instr);
                    last_d  = bus.in_last;
                    cyc_d   = 1'b1;
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    cyc_d = 1'b0;
                end
            end
            S_PROG_ON, S_INSTR_WR, S_PINS, S_PROG_OFF: begin
                if (!cyc_q) begin
                    // Entered right after another transfer: the idle gap is over.
                    cyc_d  = 1'b1;
                    wait_d = {WAIT_W{1'b0}};
                end else if (bus.wbm_ack_i) begin
                    cyc_d  = 1'b0;
                    wait_d = {WAIT_W{1'b0}};
                    case (state_q)
                        S_PROG_ON: state_d = S_INSTR_WAIT;
                        S_INSTR_WR: begin
                            if (last_q) begin
                                state_d = S_PINS;
                                adr_d   = ADR_PINS;
                                dat_d   = zext_pins(pin_q);
                            end else begin
                                state_d = S_INSTR_WAIT;
                            end
                        end
                        S_PINS: begin
                            state_d = S_PROG_OFF;
                            adr_d   = ADR_PROG;
                            dat_d   = WB_ZERO;
                        end
                        S_PROG_OFF: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            adr_d   = WB_ZERO;
                            dat_d   = WB_ZERO;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else if (wait_q == WAIT_LAST) begin
                    // Slave never answered: abort without the program-mode-off write.
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    adr_d   = WB_ZERO;
                    dat_d   = WB_ZERO;
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
        in_ready_d = (state_d == S_INSTR_WAIT);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset that drops any transfer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            adr_q      <= WB_ZERO;
            dat_q      <= WB_ZERO;
            wait_q     <= {WAIT_W{1'b0}};
            last_q     <= 1'b0;
            pin_q      <= {IO_PINS{1'b0}};
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            wait_q     <= wait_d;
            last_q     <= last_d;
            pin_q      <= pin_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = cyc_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.in_ready  = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_wb_prog_loader.sv
// Randomised bench for wb_prog_loader: a Wishbone slave with configurable ack
// latency, a stream driver, and a reference list of expected bus writes.
module tb_wb_prog_loader;
    localparam int LOG_CORES   = 1;
    localparam int PC_WIDTH    = 3;
    localparam int INSTR_WIDTH = 32;
    localparam int IO_PINS     = 8;
    localparam int WB_WIDTH    = 32;
    localparam int ACK_TIMEOUT = 15;

    typedef struct {
        logic [LOG_CORES-1:0] core;
        logic [PC_WIDTH-1:0]  pc;
        logic [31:0]          word;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [IO_PINS-1:0] pin_dir;
    logic busy, done, err;

    wb_prog_loader_if #(.LOG_CORES(LOG_CORES), .PC_WIDTH(PC_WIDTH),
                        .INSTR_WIDTH(INSTR_WIDTH), .WB_WIDTH(WB_WIDTH)) bus ();

    wb_prog_loader #(.LOG_CORES(LOG_CORES), .PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH),
                     .IO_PINS(IO_PINS), .WB_WIDTH(WB_WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .pin_dir(pin_dir),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- Wishbone slave model ----------------
    int ack_mode = 1;      // 0 zero-wait, 1 delayed, 2 never
    int fixed_delay = 1;
    bit use_rand = 1'b0;
    int rand_delay = 0;
    int stb_cnt = 0;
    int eff_delay;
    assign eff_delay = use_rand ? rand_delay : fixed_delay;
    assign bus.wbm_ack_i = (ack_mode == 0) ? (bus.wbm_cyc_o & bus.wbm_stb_o) :
                           (ack_mode == 1) ? (bus.wbm_cyc_o & bus.wbm_stb_o & (stb_cnt == eff_delay)) :
                           1'b0;

    // Slave latency counter; a new random latency after every completed transfer.
    always @(posedge clk) begin
        if (!rst && bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
        if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) rand_delay <= $urandom_range(0, 3);
    end

    // ---------------- Bus monitor ----------------
    logic [31:0] obs_adr[$];
    logic [31:0] obs_dat[$];
    int          runs[$];
    int viol_cnt = 0, hs_cnt = 0, done_cnt = 0, cyc_cycles = 0, cur_run = 0;
    logic        prev_cyc = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_adr = 32'd0, prev_dat = 32'd0;

    // Records completed writes, strobe lengths, handshakes and protocol breaches.
    always @(posedge clk) begin
        if (rst) begin
            prev_cyc <= 1'b0;
            prev_ack <= 1'b0;
            cur_run  <= 0;
        end else begin
            if (bus.wbm_cyc_o) begin
                if (bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== 1'b1) viol_cnt <= viol_cnt + 1;
                else if (prev_cyc && prev_ack) viol_cnt <= viol_cnt + 1;
                else if (prev_cyc && (bus.wbm_adr_o != prev_adr || bus.wbm_dat_o != prev_dat))
                    viol_cnt <= viol_cnt + 1;
                cur_run    <= cur_run + 1;
                cyc_cycles <= cyc_cycles + 1;
                if (bus.wbm_ack_i) begin
                    obs_adr.push_back(bus.wbm_adr_o);
                    obs_dat.push_back(bus.wbm_dat_o);
                end
            end else begin
                if (bus.wbm_stb_o || bus.wbm_we_o) viol_cnt <= viol_cnt + 1;
                if (cur_run != 0) runs.push_back(cur_run);
                cur_run <= 0;
            end
            if (bus.in_valid && bus.in_ready) hs_cnt <= hs_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            prev_cyc <= bus.wbm_cyc_o;
            prev_ack <= bus.wbm_ack_i;
            prev_adr <= bus.wbm_adr_o;
            prev_dat <= bus.wbm_dat_o;
        end
    end

    // ---------------- Reference model ----------------
    instr_t      prog[$];
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];

    task automatic build_exp(input logic [IO_PINS-1:0] pin);
        exp_adr.delete();
        exp_dat.delete();
        exp_adr.push_back(32'h4000_0000); exp_dat.push_back(32'd1);
        foreach (prog[i]) begin
            exp_adr.push_back(32'(prog[i].core) * 32'd8 + 32'(prog[i].pc));
            exp_dat.push_back(prog[i].word);
        end
        exp_adr.push_back(32'h4000_0001); exp_dat.push_back(32'(pin));
        exp_adr.push_back(32'h4000_0000); exp_dat.push_back(32'd0);
    endtask

    task automatic gen_prog(input int n);
        instr_t t;
        prog.delete();
        for (int i = 0; i < n; i++) begin
            t.core = 1'($urandom);
            t.pc   = 3'($urandom);
            t.word = $urandom;
            prog.push_back(t);
        end
    endtask

    task automatic compare_seq(input int base);
        check("n_writes", 32'(obs_adr.size() - base), 32'(exp_adr.size()));
        foreach (exp_adr[i]) begin
            if (base + i < obs_adr.size()) begin
                check("wr_adr", obs_adr[base+i], exp_adr[i]);
                check("wr_dat", obs_dat[base+i], exp_dat[i]);
            end
        end
    endtask

    // ---------------- Stimulus helpers ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic run_stream();
        foreach (prog[i]) begin
            int h0, k;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_core  = prog[i].core;
            bus.in_pc    = prog[i].pc;
            bus.in_instr = prog[i].word;
            bus.in_last  = (i == prog.size() - 1);
            h0 = hs_cnt;
            k  = 0;
            do begin
                @(negedge clk);
                k++;
            end while (hs_cnt == h0 && k < 300);
            if (hs_cnt == h0) check("hs_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            bus.in_core  = 1'($urandom);
            bus.in_pc    = 3'($urandom);
            bus.in_instr = $urandom;
            bus.in_last  = 1'($urandom);
        end
    endtask

    // flavour: 0 plain, 1 stall in INSTR_WAIT, 2 disturb during PROG_ON
    task automatic run_seq(input logic [IO_PINS-1:0] pin, input int flavour);
        int base, v0, d0, h0, c0, bad;
        base = obs_adr.size();
        v0   = viol_cnt;
        d0   = done_cnt;
        build_exp(pin);
        pin_dir = pin;
        pulse_start();
        pin_dir = 8'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_after_start", 32'(err), 32'd0);
        if (flavour == 2) begin
            h0 = hs_cnt;
            start        = 1'b1;
            pin_dir      = ~pin;
            bus.in_valid = 1'b1;
            bus.in_instr = 32'hBAD0_BAD0;
            bus.in_last  = 1'b1;
            check("ready_outside_wait", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            start        = 1'b0;
            bus.in_valid = 1'b0;
            check("no_hs_outside_wait", 32'(hs_cnt - h0), 32'd0);
        end
        if (flavour == 1) begin
            wait_ready("stall_ready");
            c0  = cyc_cycles;
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.in_ready !== 1'b1 || busy !== 1'b1 || bus.wbm_cyc_o !== 1'b0) bad++;
            end
            check("stall_bad_cycles", 32'(bad), 32'd0);
            check("stall_cyc_activity", 32'(cyc_cycles - c0), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        run_stream();
        wait_done("seq_done");
        check("seq_err", 32'(err), 32'd0);
        @(negedge clk);
        check("done_pulse_len", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        compare_seq(base);
        check("protocol_viol", 32'(viol_cnt - v0), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #800000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        int base, r0, bad;
        rst = 1'b1; start = 1'b0; pin_dir = 8'h00;
        bus.in_valid = 1'b0; bus.in_core = 1'b0; bus.in_pc = 3'd0;
        bus.in_instr = 32'd0; bus.in_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("rst_we", 32'(bus.wbm_we_o), 32'd0);
        check("rst_adr", bus.wbm_adr_o, 32'd0);
        check("rst_dat", bus.wbm_dat_o, 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Directed sequence, ack one cycle after strobe.
        ack_mode = 1; use_rand = 1'b0; fixed_delay = 1;
        prog.delete();
        t.core = 1'b0; t.pc = 3'd0; t.word = 32'h8230_000F; prog.push_back(t);
        t.core = 1'b0; t.pc = 3'd1; t.word = 32'h61E7_0001; prog.push_back(t);
        t.core = 1'b1; t.pc = 3'd2; t.word = 32'h0000_0ABC; prog.push_back(t);
        run_seq(8'hF0, 0);

        // Stream stalls in INSTR_WAIT.
        gen_prog(2);
        run_seq(8'h5A, 1);

        // Slave never acks PROG_ON: timeout abort.
        ack_mode = 2;
        base = obs_adr.size();
        r0   = runs.size();
        pin_dir = 8'hF0;
        pulse_start();
        wait_done("abort_done");
        check("abort_err", 32'(err), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort_done_len", 32'(done), 32'd0);
        check("abort_err_sticky", 32'(err), 32'd1);
        check("abort_no_writes", 32'(obs_adr.size() - base), 32'd0);
        check("abort_runs", 32'(runs.size() - r0), 32'd1);
        if (runs.size() > r0) check("abort_cyc_len", 32'(runs[runs.size()-1]), 32'(ACK_TIMEOUT));
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(bus.wbm_cyc_o), 32'd0);

        // Recovery: next start clears err.
        ack_mode = 1; fixed_delay = 1;
        gen_prog(2);
        run_seq(8'hC3, 0);

        // Zero-wait slave.
        ack_mode = 0;
        r0 = runs.size();
        gen_prog(3);
        run_seq(8'h81, 0);
        bad = 0;
        for (int i = r0; i < runs.size(); i++) if (runs[i] != 1) bad++;
        check("zw_len", 32'(bad), 32'd0);
        check("zw_nruns", 32'(runs.size() - r0), 32'(exp_adr.size()));

        // Reset during INSTR_WR with cyc high.
        ack_mode = 1; fixed_delay = 1;
        pin_dir = 8'h77;
        pulse_start();
        wait_ready("rst_test_ready");
        ack_mode = 2;
        base = hs_cnt;
        bus.in_valid = 1'b1; bus.in_core = 1'b1; bus.in_pc = 3'd5;
        bus.in_instr = 32'h1234_5678; bus.in_last = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rst_test_hs", 32'(hs_cnt - base), 32'd1);
        @(negedge clk);
        check("rst_test_cyc_pre", 32'(bus.wbm_cyc_o), 32'd1);
        check("rst_test_adr_pre", bus.wbm_adr_o, 32'h0000_000D);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("rst_mid_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mid_adr", bus.wbm_adr_o, 32'd0);

        // start and in_valid outside INSTR_WAIT are ignored.
        ack_mode = 1; fixed_delay = 3;
        gen_prog(2);
        run_seq(8'h3C, 2);
        repeat (4) @(negedge clk);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Randomised sequences.
        use_rand = 1'b1;
        for (int n = 0; n < 8; n++) begin
            ack_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
            gen_prog($urandom_range(1, 5));
            run_seq(8'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
